// File: rtl/uart_rx_fsm_pkg.sv
// uart_rx_fsm_pkg: shared state encoding and default bit timing for the UART receiver
package uart_rx_fsm_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE, BREAK} rx_states;
  localparam int DEF_CLKS_PER_BIT = 434;
endpackage

// File: rtl/uart_rx_fsm_bit_timer.sv
// rx_bit_timer: per-state clock counter flagging the middle and end of a bit period
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic mid_tick,
  output logic bit_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign mid_tick = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
  assign bit_tick = cnt_q == CW'(CLKS_PER_BIT - 1);
  // wrapping on bit_tick lets DATA sample every bit without re-entering the state
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : bit_tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 UART receiver writing good bytes into a FIFO, flagging framing errors and overruns
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 full_fifo,
  output logic                 we_fifo,
  output logic [DATA_BITS-1:0] data_fifo,
  output logic                 busy_rx,
  output logic                 frame_err,
  output logic                 overrun
);
  rx_states state_q, state_d;
  logic sync1_q, rx_s;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic we_q, we_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic mid_tick, bit_tick;
  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_d != state_q),
    .en       (state_q == START || state_q == DATA || state_q == STOP),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    we_d      = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    case (state_q)
      IDLE:  state_d = rx_s ? IDLE : START;
      START: if (mid_tick) begin
        state_d   = rx_s ? IDLE : DATA;
        bit_cnt_d = '0;
      end
      DATA:  if (bit_tick) begin
        shift_d   = (shift_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = bit_cnt_q == 4'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP:  if (bit_tick) begin
        state_d = rx_s ? WRITE : BREAK;
        ferr_d  = !rx_s;
      end
      WRITE: begin
        state_d = IDLE;
        we_d    = !full_fifo;
        ovr_d   = full_fifo;
        data_d  = full_fifo ? data_q : shift_q;
      end
      BREAK: state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rx_s      <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx;
      rx_s      <= sync1_q;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      we_q      <= we_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end
  assign we_fifo   = we_q;
  assign data_fifo = data_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy_rx   = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed bench for the UART receiver at 16 clocks per bit
module tb_uart_rx_fsm;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, full_fifo = 1'b0;
  logic we_fifo, busy_rx, frame_err, overrun;
  logic [7:0] data_fifo;
  int checks = 0, failures = 0;
  int cyc = 0, we_cnt = 0, fe_cnt = 0, ov_cnt = 0, excl_err = 0;
  int last_t = 0, prev_t = 0;
  logic [7:0] last_d = '0, prev_d = '0;
  logic p_we = 1'b0, p_fe = 1'b0, p_ov = 1'b0;

  uart_rx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .full_fifo (full_fifo),
    .we_fifo   (we_fifo),
    .data_fifo (data_fifo),
    .busy_rx   (busy_rx),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (we_fifo) begin
      we_cnt <= we_cnt + 1;
      prev_d <= last_d;
      last_d <= data_fifo;
      prev_t <= last_t;
      last_t <= cyc;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if ((32'(we_fifo) + 32'(frame_err) + 32'(overrun)) > 1 ||
        (we_fifo && p_we) || (frame_err && p_fe) || (overrun && p_ov))
      excl_err <= excl_err + 1;
    p_we <= we_fifo;
    p_fe <= frame_err;
    p_ov <= overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(stop);
  endtask

  initial begin
    int w0, f0, o0;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(we_fifo), 0);
    chk("rst_data", 32'(data_fifo), 0);
    chk("rst_busy", 32'(busy_rx), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    // 1: clean frame
    w0 = we_cnt; f0 = fe_cnt; o0 = ov_cnt;
    frame(8'hA5, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("t1_we_count", 32'(we_cnt - w0), 1);
    chk("t1_data", 32'(last_d), 32'h A5);
    chk("t1_ferr", 32'(fe_cnt - f0), 0);
    chk("t1_ovr", 32'(ov_cnt - o0), 0);
    chk("t1_busy", 32'(busy_rx), 0);
    // 2: glitch shorter than half a bit
    w0 = we_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_busy_hi", 32'(busy_rx), 1);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = !busy_rx;
    end
    chk("t2_busy_drop", 32'(seen), 1);
    repeat (2 * CPB) @(negedge clk);
    chk("t2_we", 32'(we_cnt - w0), 0);
    chk("t2_ferr", 32'(fe_cnt - f0), 0);
    // 3: framing error, line held low, then recovery
    w0 = we_cnt; f0 = fe_cnt;
    frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    chk("t3_busy_low", 32'(busy_rx), 1);
    chk("t3_ferr", 32'(fe_cnt - f0), 1);
    chk("t3_no_we", 32'(we_cnt - w0), 0);
    bit_out(1'b1);
    frame(8'h81, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("t3_we", 32'(we_cnt - w0), 1);
    chk("t3_data", 32'(last_d), 32'h81);
    // 4: overrun with FIFO full
    w0 = we_cnt; o0 = ov_cnt;
    full_fifo = 1'b1;
    frame(8'h55, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    full_fifo = 1'b0;
    chk("t4_ovr", 32'(ov_cnt - o0), 1);
    chk("t4_no_we", 32'(we_cnt - w0), 0);
    chk("t4_data_hold", 32'(data_fifo), 32'h81);
    // 5: reset during data bit 4
    w0 = we_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    chk("t5_busy", 32'(busy_rx), 0);
    chk("t5_we", 32'(we_fifo), 0);
    chk("t5_data", 32'(data_fifo), 0);
    chk("t5_ferr", 32'(frame_err), 0);
    chk("t5_ovr", 32'(overrun), 0);
    repeat (3 * CPB) @(negedge clk);
    chk("t5_no_we", 32'(we_cnt - w0), 0);
    frame(8'hFF, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("t5_we_after", 32'(we_cnt - w0), 1);
    chk("t5_data_after", 32'(last_d), 32'hFF);
    // 6: back-to-back frames
    w0 = we_cnt;
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("t6_we_count", 32'(we_cnt - w0), 2);
    chk("t6_first", 32'(prev_d), 32'h00);
    chk("t6_second", 32'(last_d), 32'hFF);
    chk("t6_gap", 32'(last_t - prev_t), 160);
    chk("pulse_exclusive", 32'(excl_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
